// File: rtl/coin_pkg.sv
// coin_pkg: definitions shared by the coin acceptor and the vending FSM.
//   COIN_NONE / COIN_ONE / COIN_TWO : the coin[1:0] codes seen by the vending FSM.
//   out_state_e                     : states of the acceptor's output sequencer.
//   coin_code()                     : maps a queued coin type bit to its code.
package coin_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_ONE  = 2'b01;
  localparam logic [1:0] COIN_TWO  = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StEmit,
    StGap
  } out_state_e;

  // Queue entries store 1 for a two-rupee coin and 0 for a one-rupee coin.
  function automatic logic [1:0] coin_code(input logic is_two);
    return is_two ? COIN_TWO : COIN_ONE;
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// coin_debounce: cleans up one raw coin-slot sensor.
//   clk_i   : system clock, rising edge
//   rst_i   : synchronous active-high reset
//   sense_i : raw asynchronous sensor level
//   rise_o  : registered one-cycle pulse when the debounced level goes 0 -> 1
// The sensor is synchronised by two flops. The debounced level flips only after
// the synchronised input has disagreed with it for DEBOUNCE_CYCLES cycles in a row.
module coin_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sense_i,
  output logic rise_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            stb_q, stb_d;
  logic            rise_q, rise_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    stb_d = stb_q;
    cnt_d = '0;
    if (sync2_q != stb_q) begin
      // The counter holds the disagreements seen so far, so the last one flips stb.
      if (cnt_q == CntLast) begin
        stb_d = ~stb_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    rise_d = stb_d & ~stb_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      stb_q   <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sense_i;
      sync2_q <= sync1_q;
      stb_q   <= stb_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: front end of the vending machine. It debounces the 1- and 2-rupee
// slot sensors, queues the insertions and replays them as single-cycle coin codes.
// Consecutive codes are always separated by at least one idle cycle.
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset, clears everything including the queue
//   sense_1 : raw 1-rupee sensor
//   sense_2 : raw 2-rupee sensor
//   coin    : registered code, 00 none / 01 one rupee / 10 two rupees
//   reject  : registered one-cycle pulse when an insertion is dropped
//   pending : queue occupancy
//   total   : saturating count of rupees emitted. It exists only when the build
//             defines COIN_TOTAL_EN.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH      = 4
`ifdef COIN_TOTAL_EN
  ,
  parameter int unsigned TOTAL_W         = 16
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sense_1,
  input  logic                        sense_2,
  output logic [1:0]                  coin,
  output logic                        reject,
  output logic [$clog2(FIFO_DEPTH):0] pending
`ifdef COIN_TOTAL_EN
  ,
  output logic [TOTAL_W-1:0]          total
`endif
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  logic            ev_1, ev_2;
  logic            fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fifo_empty;
  logic            push, pop;
  logic            reject_q, reject_d;
  logic [1:0]      coin_q, coin_d;
  out_state_e      state_q, state_d;

  coin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_1 (
    .clk_i  (clk),
    .rst_i  (rst),
    .sense_i(sense_1),
    .rise_o (ev_1)
  );

  coin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_2 (
    .clk_i  (clk),
    .rst_i  (rst),
    .sense_i(sense_2),
    .rise_o (ev_2)
  );

  assign fifo_empty = (cnt_q == '0);

  // Simultaneous insertions cannot be told apart, so both are refused. Fullness
  // uses the occupancy before any same-cycle pop.
  always_comb begin
    push     = 1'b0;
    reject_d = 1'b0;
    if (ev_1 && ev_2) begin
      reject_d = 1'b1;
    end else if (ev_1 || ev_2) begin
      if (cnt_q == CntFull) begin
        reject_d = 1'b1;
      end else begin
        push = 1'b1;
      end
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_q[i] <= 1'b0;
      end
    end else if (push) begin
      fifo_q[wr_ptr_q] <= ev_2;
    end
  end

  // Output sequencer: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      coin_q   <= COIN_NONE;
      reject_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      coin_q   <= coin_d;
      reject_q <= reject_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Output sequencer: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!fifo_empty) state_d = StEmit;
      StEmit:  state_d = StGap;
      StGap:   state_d = fifo_empty ? StIdle : StEmit;
      default: state_d = StIdle;
    endcase
  end

  // Output sequencer: pop and code. The code is registered, so it is visible
  // while the sequencer sits in StEmit.
  always_comb begin
    pop    = 1'b0;
    coin_d = COIN_NONE;
    unique case (state_q)
      StIdle, StGap: begin
        if (!fifo_empty) begin
          pop    = 1'b1;
          coin_d = coin_code(fifo_q[rd_ptr_q]);
        end
      end
      default: ;
    endcase
  end

  assign coin    = coin_q;
  assign reject  = reject_q;
  assign pending = cnt_q;

`ifdef COIN_TOTAL_EN
  logic [TOTAL_W-1:0] total_q, total_d;
  logic [TOTAL_W:0]   total_sum;

  // Add with one guard bit so that overflow becomes saturation instead of wrap.
  always_comb begin
    total_sum = {1'b0, total_q};
    if (coin_d == COIN_ONE) begin
      total_sum = total_sum + (TOTAL_W + 1)'(1);
    end else if (coin_d == COIN_TWO) begin
      total_sum = total_sum + (TOTAL_W + 1)'(2);
    end
    total_d = total_sum[TOTAL_W] ? '1 : total_sum[TOTAL_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      total_q <= '0;
    end else begin
      total_q <= total_d;
    end
  end

  assign total = total_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: bench for coin_acceptor. A transaction-level reference model
// is checked on every cycle. Directed table vectors and hand-written corner
// sequences run alongside it, followed by a randomized sensor phase.
module tb_coin_acceptor;
  import coin_pkg::*;

  localparam int Deb    = 4;
  localparam int Depth  = 4;
  localparam int PendW  = $clog2(Depth) + 1;
  localparam int TotW   = 3;
  localparam int TotMax = (1 << TotW) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sense_1 = 1'b0;
  logic             sense_2 = 1'b0;
  logic [1:0]       coin;
  logic             reject;
  logic [PendW-1:0] pending;
`ifdef COIN_TOTAL_EN
  logic [TotW-1:0]  total;
`endif

  coin_acceptor #(
    .DEBOUNCE_CYCLES(Deb),
    .FIFO_DEPTH     (Depth)
`ifdef COIN_TOTAL_EN
    ,
    .TOTAL_W        (TotW)
`endif
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sense_1(sense_1),
    .sense_2(sense_2),
    .coin   (coin),
    .reject (reject),
    .pending(pending)
`ifdef COIN_TOTAL_EN
    ,
    .total  (total)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_no  = 0;

  // Reference model state. Raw sensor runs are counted directly. A level
  // accepted on sample k becomes a queued coin three edges later.
  int         acc_lvl [2];
  int         run_lvl [2];
  int         run_len [2];
  int         due_q0 [$];
  int         due_q1 [$];
  bit         pend_q [$];
  int         last_pop;
  int         m_total;
  logic [1:0] exp_coin;
  logic       exp_rej;
  int         exp_pend;

  // Observations for the directed sequences.
  logic [1:0] seen_codes [$];
  int         seen_edges [$];
  int         seen_rej;

  typedef struct {
    int         len1;
    int         len2;
    int         off2;
    int         exp_n;
    int         exp_rej;
    logic [1:0] exp_first;
    int         exp_lat;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_no, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      acc_lvl[s] = 0;
      run_lvl[s] = 0;
      run_len[s] = 0;
    end
    due_q0.delete();
    due_q1.delete();
    pend_q.delete();
    last_pop = -10;
    m_total  = 0;
  endtask

  task automatic model_edge(input logic a, input logic b, input logic r);
    int v;
    bit ev [2];
    bit do_pop, full, code;
    if (r) begin
      model_reset();
      exp_coin = COIN_NONE;
      exp_rej  = 1'b0;
      exp_pend = 0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        v = ((s == 0) ? a : b) ? 1 : 0;
        if (v == run_lvl[s]) begin
          run_len[s]++;
        end else begin
          run_lvl[s] = v;
          run_len[s] = 1;
        end
        if (run_len[s] == Deb && v != acc_lvl[s]) begin
          acc_lvl[s] = v;
          if (v == 1) begin
            if (s == 0) due_q0.push_back(edge_no + 3);
            else        due_q1.push_back(edge_no + 3);
          end
        end
      end
      ev[0] = (due_q0.size() > 0) && (due_q0[0] == edge_no);
      ev[1] = (due_q1.size() > 0) && (due_q1[0] == edge_no);
      if (ev[0]) void'(due_q0.pop_front());
      if (ev[1]) void'(due_q1.pop_front());
      // A coin leaves whenever one is waiting and none left on the previous edge.
      do_pop  = (pend_q.size() > 0) && (last_pop != edge_no - 1);
      full    = (pend_q.size() == Depth);
      exp_rej = (ev[0] && ev[1]) || ((ev[0] ^ ev[1]) && full);
      if (do_pop) begin
        code     = pend_q.pop_front();
        exp_coin = code ? COIN_TWO : COIN_ONE;
        last_pop = edge_no;
        m_total  = m_total + (code ? 2 : 1);
        if (m_total > TotMax) m_total = TotMax;
      end else begin
        exp_coin = COIN_NONE;
      end
      if ((ev[0] ^ ev[1]) && !full) pend_q.push_back(ev[1]);
      exp_pend = pend_q.size();
    end
  endtask

  task automatic step(input logic a, input logic b, input logic r);
    sense_1 = a;
    sense_2 = b;
    rst     = r;
    @(posedge clk);
    edge_no++;
    model_edge(a, b, r);
    #1;
    check("coin", 32'(coin), 32'(exp_coin));
    check("reject", 32'(reject), 32'(exp_rej));
    check("pending", 32'(pending), exp_pend);
`ifdef COIN_TOTAL_EN
    check("total", 32'(total), m_total);
`endif
    if (coin != COIN_NONE) begin
      seen_codes.push_back(coin);
      seen_edges.push_back(edge_no);
    end
    if (reject) seen_rej++;
  endtask

  task automatic clear_obs();
    seen_codes.delete();
    seen_edges.delete();
    seen_rej = 0;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    clear_obs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int base, lat, rate;
    bit found;
    logic r1, r2;
    int rem1, rem2;
    logic [1:0] first;

    vecs[0] = '{10, 0, 0, 1, 0, COIN_ONE, 7};   // single one-rupee coin
    vecs[1] = '{0, 3, 0, 0, 0, COIN_NONE, -1};  // glitch shorter than debounce
    vecs[2] = '{0, 10, 0, 1, 0, COIN_TWO, 7};   // single two-rupee coin
    vecs[3] = '{6, 6, 0, 0, 1, COIN_NONE, -1};  // simultaneous insertions
    vecs[4] = '{6, 6, 1, 2, 0, COIN_ONE, 7};    // one cycle apart, both accepted
    vecs[5] = '{3, 3, 0, 0, 0, COIN_NONE, -1};  // both just below threshold
    vecs[6] = '{4, 0, 0, 1, 0, COIN_ONE, 7};    // exactly at threshold
    vecs[7] = '{0, 4, 2, 1, 0, COIN_TWO, 9};    // delayed start

    do_reset();
    check("reset_coin", 32'(coin), 32'(COIN_NONE));
    check("reset_pending", 32'(pending), 0);

    foreach (vecs[i]) begin
      do_reset();
      base = edge_no + 1;
      for (int c = 0; c < 40; c++) begin
        step(c < vecs[i].len1, (c >= vecs[i].off2) && (c < vecs[i].off2 + vecs[i].len2), 1'b0);
      end
      first = (seen_codes.size() > 0) ? seen_codes[0] : COIN_NONE;
      lat   = (seen_edges.size() > 0) ? seen_edges[0] - base : -1;
      check($sformatf("vec%0d_ncoins", i), seen_codes.size(), vecs[i].exp_n);
      check($sformatf("vec%0d_rejects", i), seen_rej, vecs[i].exp_rej);
      check($sformatf("vec%0d_first", i), 32'(first), 32'(vecs[i].exp_first));
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_drained", i), 32'(pending), 0);
    end

    // Burst 1, 2, 1 rupees spaced six cycles apart.
    do_reset();
    base = edge_no + 1;
    for (int c = 0; c < 45; c++) begin
      step((c < 5) || (c >= 12 && c < 17), (c >= 6) && (c < 11), 1'b0);
    end
    check("burst_n", seen_codes.size(), 3);
    if (seen_codes.size() == 3) begin
      check("burst_c0", 32'(seen_codes[0]), 32'(COIN_ONE));
      check("burst_c1", 32'(seen_codes[1]), 32'(COIN_TWO));
      check("burst_c2", 32'(seen_codes[2]), 32'(COIN_ONE));
      check("burst_lat", seen_edges[0] - base, 7);
      check("burst_gap1", seen_edges[1] - seen_edges[0], 6);
      check("burst_gap2", seen_edges[2] - seen_edges[1], 6);
    end

    // Six two-rupee coins as fast as the debouncer allows, then the same stream
    // with one-rupee coins interleaved one cycle behind.
    for (int mix = 0; mix < 2; mix++) begin
      do_reset();
      for (int c = 0; c < 6 * 2 * Deb + 30; c++) begin
        rate = c % (2 * Deb);
        step((mix == 1) && (c >= 1) && (c < 6 * 2 * Deb) && ((c - 1) % (2 * Deb) < Deb),
             (c < 6 * 2 * Deb) && (rate < Deb), 1'b0);
      end
      check($sformatf("fast%0d_n", mix), seen_codes.size(), (mix == 1) ? 12 : 6);
      check($sformatf("fast%0d_rej", mix), seen_rej, 0);
    end

    // Reset while a coin is being emitted: the coin still queued is lost.
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      step(c < 6, (c >= 1) && (c < 7), 1'b0);
      if (coin != COIN_NONE) found = 1'b1;
    end
    check("emit_wait", 32'(found), 1);
    check("emit_backlog", 32'(pending), 1);
    step(1'b0, 1'b0, 1'b1);
    check("rst_mid_coin", 32'(coin), 32'(COIN_NONE));
    check("rst_mid_pending", 32'(pending), 0);
    clear_obs();
    idle(25);
    check("rst_mid_no_coin", seen_codes.size(), 0);

    // Sensor held high across reset is debounced again and counts once.
    do_reset();
    for (int c = 0; c < 6; c++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    clear_obs();
    base = edge_no + 1;
    for (int c = 0; c < 10; c++) step(1'b1, 1'b0, 1'b0);
    idle(15);
    check("held_n", seen_codes.size(), 1);
    if (seen_codes.size() == 1) check("held_lat", seen_edges[0] - base, 7);

`ifdef COIN_TOTAL_EN
    do_reset();
    for (int c = 0; c < 80; c++) step(1'b0, (c % 10) < 5, 1'b0);
    idle(10);
    check("total_saturated", 32'(total), TotMax);
`endif

    // Randomized sensor activity with occasional resets.
    do_reset();
    r1 = 1'b0;
    r2 = 1'b0;
    rem1 = 0;
    rem2 = 0;
    for (int c = 0; c < 800; c++) begin
      if (rem1 == 0) begin
        r1   = ~r1;
        rem1 = $urandom_range(12, 1);
      end
      if (rem2 == 0) begin
        r2   = ~r2;
        rem2 = $urandom_range(12, 1);
      end
      rem1--;
      rem2--;
      step(r1, r2, $urandom_range(199, 0) == 0);
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
